stream_serializer_eof2: RTL and testbench

STREAM_SERIALIZER_EOF2 -- requirements
Module: stream_serializer_eof2

---
 rtl/stream_serializer_eof2.sv | 118 +++++++++++
 tb/tb_stream_serializer_eof2.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/stream_serializer_eof2.sv
`default_nettype none
// ============================================================================
// Module      : stream_serializer_eof2
// Description : Serializes a parallel word of Ratio slices into a stream of
//               DataBits-wide elements, little endian (slice 0 first). The
//               lowest set in_eof bit ends the word early and is flagged on
//               out_eof. A new word loads on the edge that drains the last
//               element, so back-to-back words have no idle cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_serializer_eof2 #(
  parameter int DataBits = 8,
  parameter int Ratio    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [Ratio*DataBits-1:0] in_data,
  input  logic [Ratio-1:0]          in_eof,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DataBits-1:0]       out_data,
  output logic                      out_eof
);

  // A one-slice "word" would need no serializer; the index is kept at least
  // one bit wide so the degenerate case still elaborates.
  localparam int c_CNT_W = (Ratio > 1) ? $clog2(Ratio) : 1;

  localparam logic [0:0] c_IDLE = 1'b0;
  localparam logic [0:0] c_BUSY = 1'b1;

  logic [0:0]                state_q, state_d;
  logic [c_CNT_W-1:0]        count_q, count_d;
  logic [Ratio*DataBits-1:0] data_q;
  logic [Ratio-1:0]          eof_q;

  logic [DataBits-1:0]       w_sel_data;
  logic                      w_sel_eof;
  logic                      w_last;
  logic                      w_accept;

  // Select the slice and its end-of-frame flag addressed by the slice index.
  always_comb begin
    w_sel_data = data_q[DataBits-1:0];
    w_sel_eof  = eof_q[0];
    for (int k = 1; k < Ratio; k++) begin
      if (count_q == c_CNT_W'(k)) begin
        w_sel_data = data_q[k*DataBits +: DataBits];
        w_sel_eof  = eof_q[k];
      end
    end
  end

  // The current element closes the word if it is the top slice or is flagged.
  assign w_last   = (count_q == c_CNT_W'(Ratio - 1)) | w_sel_eof;
  assign w_accept = in_valid & in_ready;

  // State and slice index register; reset drops any partially sent word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= c_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Next-state logic: advance on each transfer, reload or idle after the last.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      c_IDLE: begin
        if (in_valid) begin
          state_d = c_BUSY;
          count_d = '0;
        end
      end
      c_BUSY: begin
        if (out_ready) begin
          if (!w_last) begin
            count_d = count_q + c_CNT_W'(1);
          end else if (in_valid) begin
            count_d = '0;
          end else begin
            state_d = c_IDLE;
            count_d = '0;
          end
        end
      end
      default: begin
        state_d = c_IDLE;
        count_d = '0;
      end
    endcase
  end

  // Output logic: valid while a word is held; accept when empty or draining.
  always_comb begin
    out_valid = (state_q == c_BUSY);
    out_data  = w_sel_data;
    out_eof   = (state_q == c_BUSY) & w_sel_eof;
    in_ready  = (state_q == c_IDLE) | ((state_q == c_BUSY) & out_ready & w_last);
  end

  // Held word; contents are only meaningful while busy, so no reset needed.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      data_q <= in_data;
      eof_q  <= in_eof;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stream_serializer_eof2.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_serializer_eof2
// Description : Self-checking bench for stream_serializer_eof2. Directed
//               vector table, hand sequences for async reset and Ratio=3,
//               then random traffic against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_serializer_eof2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, out_eof;
  logic [15:0] in_data;
  logic [1:0]  in_eof;
  logic [7:0]  out_data;

  logic        v3, ir3, ov3, r3, oe3;
  logic [23:0] d3;
  logic [2:0]  e3;
  logic [7:0]  od3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  stream_serializer_eof2 #(.DataBits(8), .Ratio(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_eof(in_eof),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_eof(out_eof)
  );

  stream_serializer_eof2 #(.DataBits(8), .Ratio(3)) dut3 (
    .clk(clk), .rst(rst),
    .in_valid(v3), .in_ready(ir3), .in_data(d3), .in_eof(e3),
    .out_valid(ov3), .out_ready(r3), .out_data(od3), .out_eof(oe3)
  );

  typedef struct packed {
    logic        v;
    logic [15:0] d;
    logic [1:0]  e;
    logic        r;
    logic        ov;
    logic [7:0]  od;
    logic        oe;
    logic        ir;
  } vec_t;

  vec_t tbl[19];

  // Reference model: elements of the held word still to be sent, {eof,data}.
  logic [8:0] q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic [15:0] d, input logic [1:0] e,
                              input logic r, input logic ov, input logic [7:0] od,
                              input logic oe, input logic ir);
    vec_t t;
    t.v = v; t.d = d; t.e = e; t.r = r; t.ov = ov; t.od = od; t.oe = oe; t.ir = ir;
    return t;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0]  exp3[$];
    logic [2:0]  eofs3[4];
    logic        e_ov, e_oe, e_ir;
    logic [7:0]  e_od;
    logic        do_rst;

    //        v     data      eof    r     ov    od     oe    ir
    tbl[0]  = mk(1, 16'hBBAA, 2'b00, 1, 0, 8'h00, 0, 1);
    tbl[1]  = mk(0, 16'h0000, 2'b00, 1, 1, 8'hAA, 0, 0);
    tbl[2]  = mk(0, 16'h0000, 2'b00, 1, 1, 8'hBB, 0, 1);
    tbl[3]  = mk(1, 16'h2211, 2'b01, 1, 0, 8'h00, 0, 1);
    tbl[4]  = mk(1, 16'h0201, 2'b00, 1, 1, 8'h11, 1, 1);
    tbl[5]  = mk(1, 16'h0403, 2'b00, 1, 1, 8'h01, 0, 0);
    tbl[6]  = mk(1, 16'h0403, 2'b00, 1, 1, 8'h02, 0, 1);
    tbl[7]  = mk(0, 16'h0000, 2'b00, 1, 1, 8'h03, 0, 0);
    tbl[8]  = mk(0, 16'h0000, 2'b00, 1, 1, 8'h04, 0, 1);
    tbl[9]  = mk(0, 16'h0000, 2'b00, 1, 0, 8'h00, 0, 1);
    tbl[10] = mk(1, 16'hBBAA, 2'b00, 0, 0, 8'h00, 0, 1);
    tbl[11] = mk(0, 16'h0000, 2'b00, 0, 1, 8'hAA, 0, 0);
    tbl[12] = mk(0, 16'h0000, 2'b00, 0, 1, 8'hAA, 0, 0);
    tbl[13] = mk(0, 16'h0000, 2'b00, 0, 1, 8'hAA, 0, 0);
    tbl[14] = mk(0, 16'h0000, 2'b00, 1, 1, 8'hAA, 0, 0);
    tbl[15] = mk(0, 16'h0000, 2'b00, 1, 1, 8'hBB, 0, 1);
    tbl[16] = mk(1, 16'hBBAA, 2'b11, 1, 0, 8'h00, 0, 1);
    tbl[17] = mk(0, 16'h0000, 2'b00, 1, 1, 8'hAA, 1, 1);
    tbl[18] = mk(0, 16'h0000, 2'b00, 1, 0, 8'h00, 0, 1);

    rst = 1'b1; in_valid = 0; in_data = '0; in_eof = '0; out_ready = 0;
    v3 = 0; d3 = '0; e3 = '0; r3 = 1;
    @(negedge clk);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_out_eof",   {31'd0, out_eof},   32'd0);
    chk("reset_in_ready",  {31'd0, in_ready},  32'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed vector table
    for (int i = 0; i < 19; i++) begin
      in_valid = tbl[i].v; in_data = tbl[i].d; in_eof = tbl[i].e; out_ready = tbl[i].r;
      @(negedge clk);
      chk($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].ov});
      chk($sformatf("vec%0d_in_ready", i),  {31'd0, in_ready},  {31'd0, tbl[i].ir});
      chk($sformatf("vec%0d_out_eof", i),   {31'd0, out_eof},   {31'd0, tbl[i].oe});
      if (tbl[i].ov) chk($sformatf("vec%0d_out_data", i), {24'd0, out_data}, {24'd0, tbl[i].od});
      @(posedge clk); #1;
    end

    // Async reset while slice 1 is presented, then a fresh word
    in_valid = 1; in_data = 16'hBBAA; in_eof = 2'b00; out_ready = 0;
    @(posedge clk); #1;
    in_valid = 0; out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    #1;
    chk("arst_pre_valid", {31'd0, out_valid}, 32'd1);
    chk("arst_pre_data",  {24'd0, out_data},  32'hBB);
    #1 rst = 1'b1;
    #1;
    chk("arst_valid_drop", {31'd0, out_valid}, 32'd0);
    chk("arst_in_ready",   {31'd0, in_ready},  32'd1);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("arst_idle_after", {31'd0, out_valid}, 32'd0);
    in_valid = 1; in_data = 16'hDDCC; out_ready = 1;
    @(posedge clk); #1;
    in_valid = 0;
    @(negedge clk);
    chk("arst_word_cc_valid", {31'd0, out_valid}, 32'd1);
    chk("arst_word_cc", {24'd0, out_data}, 32'hCC);
    @(posedge clk); #1;
    @(negedge clk);
    chk("arst_word_dd", {24'd0, out_data}, 32'hDD);
    @(posedge clk); #1;

    // Ratio=3 instance: several eof patterns including non-power-of-2 top slice
    eofs3[0] = 3'b100; eofs3[1] = 3'b000; eofs3[2] = 3'b010; eofs3[3] = 3'b011;
    for (int p = 0; p < 4; p++) begin
      exp3.delete();
      for (int k = 0; k < 3; k++) begin
        exp3.push_back({eofs3[p][k], 8'(8'h11 * (k + 1))});
        if (eofs3[p][k]) break;
      end
      v3 = 1; d3 = 24'h332211; e3 = eofs3[p]; r3 = 1;
      @(negedge clk);
      chk($sformatf("r3_p%0d_ready", p), {31'd0, ir3}, 32'd1);
      @(posedge clk); #1;
      v3 = 0;
      foreach (exp3[k]) begin
        @(negedge clk);
        chk($sformatf("r3_p%0d_e%0d_valid", p, k), {31'd0, ov3}, 32'd1);
        chk($sformatf("r3_p%0d_e%0d_data", p, k),  {24'd0, od3}, {24'd0, exp3[k][7:0]});
        chk($sformatf("r3_p%0d_e%0d_eof", p, k),   {31'd0, oe3}, {31'd0, exp3[k][8]});
        @(posedge clk); #1;
      end
      @(negedge clk);
      chk($sformatf("r3_p%0d_idle", p), {31'd0, ov3}, 32'd0);
      @(posedge clk); #1;
    end

    // Random traffic against the reference model (DUT is idle here)
    q.delete();
    for (int n = 0; n < 3000; n++) begin
      do_rst    = ($urandom_range(0, 149) == 0);
      in_valid  = $urandom_range(0, 1);
      in_data   = 16'($urandom);
      in_eof    = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
      out_ready = ($urandom_range(0, 3) != 0);
      if (do_rst) begin
        rst = 1'b1;
        q.delete();
        @(negedge clk);
        chk("rnd_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rnd_rst_ready", {31'd0, in_ready},  32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        continue;
      end
      @(negedge clk);
      e_ov = (q.size() != 0);
      e_od = e_ov ? q[0][7:0] : 8'h00;
      e_oe = e_ov ? q[0][8] : 1'b0;
      e_ir = (q.size() == 0) || ((q.size() == 1) && out_ready);
      chk("rnd_out_valid", {31'd0, out_valid}, {31'd0, e_ov});
      chk("rnd_out_eof",   {31'd0, out_eof},   {31'd0, e_oe});
      chk("rnd_in_ready",  {31'd0, in_ready},  {31'd0, e_ir});
      if (e_ov) chk("rnd_out_data", {24'd0, out_data}, {24'd0, e_od});
      if (e_ov && out_ready) void'(q.pop_front());
      if (in_valid && e_ir) begin
        for (int k = 0; k < 2; k++) begin
          q.push_back({in_eof[k], in_data[k*8 +: 8]});
          if (in_eof[k]) break;
        end
      end
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
